// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX boundary: enable levels, register zero,
// ALU opcodes, bubble encoding and the producer/source match helper.
package id_ex_stage_pkg;

  localparam logic       RST_ENABLED   = 1'b1;
  localparam logic       WRITE_ENABLED = 1'b1;
  localparam logic       READ_ENABLED  = 1'b1;
  localparam logic [4:0] REG_ZERO      = 5'd0;

  typedef enum logic [4:0] {
    ALUOP_NOP = 5'd0,
    ALUOP_ADD = 5'd1,
    ALUOP_SUB = 5'd2,
    ALUOP_AND = 5'd3,
    ALUOP_OR  = 5'd4,
    ALUOP_XOR = 5'd5,
    ALUOP_NOR = 5'd6,
    ALUOP_SLT = 5'd7,
    ALUOP_SLL = 5'd8,
    ALUOP_SRL = 5'd9,
    ALUOP_SRA = 5'd10,
    ALUOP_LUI = 5'd11
  } aluop_e;

  // A bubble is an all-zero latch entry: invalid, no write, no memory access, NOP.
  localparam logic   BUBBLE_VALID = 1'b0;
  localparam aluop_e BUBBLE_ALUOP = ALUOP_NOP;

  function automatic logic src_match(input logic       prod_valid,
                                     input logic       prod_wena,
                                     input logic [4:0] prod_waddr,
                                     input logic [4:0] src,
                                     input logic       src_rena);
    return prod_valid && (prod_wena == WRITE_ENABLED) && (prod_waddr != REG_ZERO) &&
           (prod_waddr == src) && (src_rena == READ_ENABLED);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_fwd_unit.sv
// Combinational RAW resolution for both ID sources: EX/MEM match, operand priority
// mux and hazard flag. Bypass muxes exist only when ID_EX_FWD_EN is defined.
module hazard_fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_rena1,
  input  logic              id_rena2,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic              ex_valid,
  input  logic              ex_wena,
  input  logic [4:0]        ex_waddr,
  input  logic              ex_mem_read,
  input  logic [DATA_W-1:0] ex_res,
  input  logic              mem_wena,
  input  logic [4:0]        mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              hazard
);

  logic ex_match_a;
  logic ex_match_b;
  logic mem_match_a;
  logic mem_match_b;
  logic load_use;

  assign ex_match_a  = src_match(ex_valid, ex_wena, ex_waddr, id_rs, id_rena1);
  assign ex_match_b  = src_match(ex_valid, ex_wena, ex_waddr, id_rt, id_rena2);
  assign mem_match_a = src_match(1'b1, mem_wena, mem_waddr, id_rs, id_rena1);
  assign mem_match_b = src_match(1'b1, mem_wena, mem_waddr, id_rt, id_rena2);
  assign load_use    = ex_mem_read & (ex_match_a | ex_match_b);

`ifdef ID_EX_FWD_EN
  always_comb begin
    op_a = id_rdata1;
    if (id_rs == REG_ZERO) begin
      op_a = '0;
    end else if (ex_match_a && !ex_mem_read) begin
      op_a = ex_res;
    end else if (mem_match_a) begin
      op_a = mem_wdata;
    end
  end

  always_comb begin
    op_b = id_rdata2;
    if (id_rt == REG_ZERO) begin
      op_b = '0;
    end else if (ex_match_b && !ex_mem_read) begin
      op_b = ex_res;
    end else if (mem_match_b) begin
      op_b = mem_wdata;
    end
  end

  // Only a load in EX cannot be bypassed; its data appears in MEM one cycle later.
  assign hazard = load_use;
`else
  logic unused_fwd;

  assign op_a   = id_rdata1;
  assign op_b   = id_rdata2;
  // Without bypass the consumer waits until the producer has left MEM.
  assign hazard = ex_match_a | ex_match_b | mem_match_a | mem_match_b;

  assign unused_fwd = ^{ex_res, mem_wdata, load_use};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch with RAW hazard handling and a saturating stall counter.
// Build option: define ID_EX_FWD_EN to enable the EX/MEM operand bypass.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [31:0]        id_pc,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rena1,
  input  logic               id_rena2,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [4:0]         id_waddr,
  input  logic               id_wena,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic [DATA_W-1:0]  ex_res,
  input  logic               mem_wena,
  input  logic [4:0]         mem_waddr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               flush,
  input  logic               ex_hold,
  output logic               stall_req,
  output logic               ex_valid,
  output logic [31:0]        ex_pc,
  output logic [DATA_W-1:0]  ex_op_a,
  output logic [DATA_W-1:0]  ex_op_b,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [4:0]         ex_waddr,
  output logic               ex_wena,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic               valid_q,     valid_d;
  logic [31:0]        pc_q,        pc_d;
  logic [DATA_W-1:0]  op_a_q,      op_a_d;
  logic [DATA_W-1:0]  op_b_q,      op_b_d;
  logic [DATA_W-1:0]  imm_q,       imm_d;
  logic [ALUOP_W-1:0] aluop_q,     aluop_d;
  logic [4:0]         waddr_q,     waddr_d;
  logic               wena_q,      wena_d;
  logic               mem_read_q,  mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [DATA_W-1:0]  sel_op_a;
  logic [DATA_W-1:0]  sel_op_b;
  logic               hazard;

  hazard_fwd_unit #(
    .DATA_W (DATA_W)
  ) u_hazard_fwd (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rena1    (id_rena1),
    .id_rena2    (id_rena2),
    .id_rdata1   (id_rdata1),
    .id_rdata2   (id_rdata2),
    .ex_valid    (valid_q),
    .ex_wena     (wena_q),
    .ex_waddr    (waddr_q),
    .ex_mem_read (mem_read_q),
    .ex_res      (ex_res),
    .mem_wena    (mem_wena),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .op_a        (sel_op_a),
    .op_b        (sel_op_b),
    .hazard      (hazard)
  );

  // A flush kills the ID instruction, so it never asks upstream to hold.
  assign stall_req = id_valid & ~flush & (hazard | ex_hold);

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    imm_d       = imm_q;
    aluop_d     = aluop_q;
    waddr_d     = waddr_q;
    wena_d      = wena_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush || (!ex_hold && hazard)) begin
      valid_d     = BUBBLE_VALID;
      pc_d        = '0;
      op_a_d      = '0;
      op_b_d      = '0;
      imm_d       = '0;
      aluop_d     = ALUOP_W'(BUBBLE_ALUOP);
      waddr_d     = REG_ZERO;
      wena_d      = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!ex_hold) begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      op_a_d      = sel_op_a;
      op_b_d      = sel_op_b;
      imm_d       = id_imm;
      aluop_d     = id_aluop;
      waddr_d     = id_waddr;
      wena_d      = id_wena;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_req && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLED) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      imm_q       <= '0;
      aluop_q     <= '0;
      waddr_q     <= '0;
      wena_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      imm_q       <= imm_d;
      aluop_q     <= aluop_d;
      waddr_q     <= waddr_d;
      wena_q      <= wena_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_op_a      = op_a_q;
  assign ex_op_b      = op_b_q;
  assign ex_imm       = imm_q;
  assign ex_aluop     = aluop_q;
  assign ex_waddr     = waddr_q;
  assign ex_wena      = wena_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios then randomized traffic,
// checked against a reference model of the ID/EX boundary kept in the bench.
`timescale 1ns/1ps
module tb_id_ex_stage;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 5;
  localparam int CNT_W   = 4;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
  localparam int T5_BUBBLES = 0;
`else
  localparam bit FWD = 1'b0;
  localparam int T5_BUBBLES = 2;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  aluop;
    logic [4:0]  waddr;
    logic        wena;
    logic        mr;
    logic        mw;
  } ex_t;

  typedef struct {
    logic rst, id_valid, rena1, rena2, wena, mr, mw, mem_wena, flush, ex_hold;
    logic [31:0] pc, rdata1, rdata2, imm, ex_res, mem_wdata;
    logic [4:0]  rs, rt, aluop, waddr, mem_waddr;
  } stim_t;

  typedef struct {
    ex_t             ex;
    logic [CNT_W-1:0] cnt;
    bit              all;
  } seq_t;

  logic clk = 1'b0;
  logic rst = 1'b0, id_valid = 1'b0, id_rena1 = 1'b0, id_rena2 = 1'b0;
  logic [31:0] id_pc = '0, id_rdata1 = '0, id_rdata2 = '0, id_imm = '0, ex_res = '0, mem_wdata = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_aluop = '0, id_waddr = '0, mem_waddr = '0;
  logic id_wena = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0, mem_wena = 1'b0;
  logic flush = 1'b0, ex_hold = 1'b0;
  logic stall_req, ex_valid, ex_wena, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_aluop, ex_waddr;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_rena1(id_rena1), .id_rena2(id_rena2), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_aluop(id_aluop), .id_waddr(id_waddr), .id_wena(id_wena),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .ex_res(ex_res),
    .mem_wena(mem_wena), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .flush(flush), .ex_hold(ex_hold), .stall_req(stall_req), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .ex_aluop(ex_aluop), .ex_waddr(ex_waddr), .ex_wena(ex_wena),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall_cycles(stall_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit   q_comb[$];
  seq_t q_seq[$];

  // Reference state: the instruction sitting in EX, the one heading into MEM, the counter.
  ex_t m_ex;
  logic m_known = 1'b0;
  logic [CNT_W-1:0] m_cnt;
  logic mp_wena = 1'b0;
  logic [4:0] mp_waddr = '0;
  bit model_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (q_comb.size() > 0) chk("stall_req", {31'd0, stall_req}, {31'd0, q_comb.pop_front()});
  end

  initial forever begin
    seq_t e;
    @(posedge clk);
    #1;
    if (q_seq.size() > 0) begin
      e = q_seq.pop_front();
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.ex.valid});
      chk("ex_wena", {31'd0, ex_wena}, {31'd0, e.ex.wena});
      chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.ex.mr});
      chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, e.ex.mw});
      chk("stall_cycles", {28'd0, stall_cycles}, {28'd0, e.cnt});
      if (e.all) begin
        chk("ex_pc", ex_pc, e.ex.pc);
        chk("ex_op_a", ex_op_a, e.ex.a);
        chk("ex_op_b", ex_op_b, e.ex.b);
        chk("ex_imm", ex_imm, e.ex.imm);
        chk("ex_aluop", {27'd0, ex_aluop}, {27'd0, e.ex.aluop});
        chk("ex_waddr", {27'd0, ex_waddr}, {27'd0, e.ex.waddr});
      end
    end
  end

  // Operand value and hazard contribution for one source, from the bypass rules.
  function automatic void resolve(input logic [4:0] src, input logic rena, input logic [31:0] rdata,
                                  input stim_t s, output logic [31:0] val, output logic hz);
    logic in_ex, in_mem;
    in_ex  = m_ex.valid && m_ex.wena && src != 0 && m_ex.waddr == src && rena;
    in_mem = s.mem_wena && src != 0 && s.mem_waddr == src && rena;
    if (FWD) begin
      hz = in_ex && m_ex.mr;
      if (src == 0) val = 32'd0;
      else if (in_ex && !m_ex.mr) val = s.ex_res;
      else if (in_mem) val = s.mem_wdata;
      else val = rdata;
    end else begin
      hz  = in_ex || in_mem;
      val = rdata;
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic step(input stim_t s_in, input bit auto_mem);
    stim_t s;
    ex_t nx;
    logic [31:0] va, vb;
    logic ha, hb, stall;
    seq_t e;
    s = s_in;
    if (auto_mem) begin
      s.mem_wena  = mp_wena;
      s.mem_waddr = mp_waddr;
    end
    @(posedge clk);
    #2;
    rst = s.rst; id_valid = s.id_valid; id_pc = s.pc; id_rs = s.rs; id_rt = s.rt;
    id_rena1 = s.rena1; id_rena2 = s.rena2; id_rdata1 = s.rdata1; id_rdata2 = s.rdata2;
    id_imm = s.imm; id_aluop = s.aluop; id_waddr = s.waddr; id_wena = s.wena;
    id_mem_read = s.mr; id_mem_write = s.mw; ex_res = s.ex_res; mem_wena = s.mem_wena;
    mem_waddr = s.mem_waddr; mem_wdata = s.mem_wdata; flush = s.flush; ex_hold = s.ex_hold;

    resolve(s.rs, s.rena1, s.rdata1, s, va, ha);
    resolve(s.rt, s.rena2, s.rdata2, s, vb, hb);
    stall = s.id_valid && !s.flush && (ha || hb || s.ex_hold);
    model_stall = stall;
    if (m_known) q_comb.push_back(stall);

    if (s.rst || s.ex_hold) begin
      mp_wena = 1'b0; mp_waddr = '0;
    end else begin
      mp_wena = m_ex.valid && m_ex.wena; mp_waddr = m_ex.waddr;
    end

    if (s.rst || s.flush) nx = '0;
    else if (s.ex_hold) nx = m_ex;
    else if (ha || hb) nx = '0;
    else nx = '{valid: s.id_valid, pc: s.pc, a: va, b: vb, imm: s.imm, aluop: s.aluop,
                waddr: s.waddr, wena: s.wena, mr: s.mr, mw: s.mw};

    if (s.rst) m_cnt = '0;
    else if (stall && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;

    e.ex = nx; e.cnt = m_cnt; e.all = nx.valid || s.rst;
    q_seq.push_back(e);
    m_ex = nx;
    if (s.rst) m_known = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst      = ($urandom_range(0, 39) == 0);
    s.id_valid = ($urandom_range(0, 7) != 0);
    s.pc       = {$urandom_range(0, 32'h3FFF), 2'b00};
    s.rs       = 5'($urandom_range(0, 3));
    s.rt       = 5'($urandom_range(0, 3));
    s.rena1    = ($urandom_range(0, 3) != 0);
    s.rena2    = ($urandom_range(0, 3) != 0);
    s.rdata1   = (s.rs == 0) ? 32'd0 : $urandom;
    s.rdata2   = (s.rt == 0) ? 32'd0 : $urandom;
    s.imm      = $urandom;
    s.aluop    = 5'($urandom_range(0, 11));
    s.waddr    = 5'($urandom_range(0, 3));
    s.wena     = ($urandom_range(0, 3) != 0);
    s.mr       = ($urandom_range(0, 3) == 0);
    s.mw       = ($urandom_range(0, 7) == 0);
    s.ex_res   = $urandom;
    s.mem_wena = 1'b0;
    s.mem_waddr = '0;
    s.mem_wdata = $urandom;
    s.flush    = ($urandom_range(0, 9) == 0);
    s.ex_hold  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    int guard;

    s = idle(); s.rst = 1'b1;
    step(s, 1); step(s, 1);

    // add $1 in EX, consumer of $1 as rs with ex_res=0x10
    s = idle(); s.id_valid = 1; s.wena = 1; s.waddr = 1; s.aluop = 5'd1; s.pc = 32'h100;
    step(s, 0);
    s = idle(); s.id_valid = 1; s.rs = 1; s.rena1 = 1; s.rdata1 = 32'hDEAD; s.ex_res = 32'h10;
    s.pc = 32'h104; step(s, 0);

    // lw $2 then use $2 as rt; retry with the load data in MEM
    s = idle(); s.rst = 1; step(s, 0);
    s = idle(); s.id_valid = 1; s.wena = 1; s.waddr = 2; s.mr = 1; s.pc = 32'h200; step(s, 0);
    s = idle(); s.id_valid = 1; s.rt = 2; s.rena2 = 1; s.rdata2 = 32'h1111; s.pc = 32'h204;
    step(s, 0);
    s.mem_wena = 1; s.mem_waddr = 2; s.mem_wdata = 32'hABCD; step(s, 0);

    // $3 written by both EX (0x1) and MEM (0x2); then a producer of $0
    s = idle(); s.rst = 1; step(s, 0);
    s = idle(); s.id_valid = 1; s.wena = 1; s.waddr = 3; s.pc = 32'h300; step(s, 0);
    s = idle(); s.id_valid = 1; s.rs = 3; s.rena1 = 1; s.rdata1 = 32'h9; s.ex_res = 32'h1;
    s.mem_wena = 1; s.mem_waddr = 3; s.mem_wdata = 32'h2; s.pc = 32'h304; step(s, 0);
    s = idle(); s.rst = 1; step(s, 0);
    s = idle(); s.id_valid = 1; s.wena = 1; s.waddr = 0; s.pc = 32'h308; step(s, 0);
    s = idle(); s.id_valid = 1; s.rs = 0; s.rena1 = 1; s.rdata1 = 32'h77; s.ex_res = 32'h5;
    s.mem_wena = 1; s.mem_waddr = 0; s.mem_wdata = 32'h5; s.pc = 32'h30C; step(s, 0);

    // flush against a load-use hazard, then ex_hold freezes a live entry
    s = idle(); s.rst = 1; step(s, 0);
    s = idle(); s.id_valid = 1; s.wena = 1; s.waddr = 6; s.mr = 1; s.pc = 32'h400; step(s, 0);
    s = idle(); s.id_valid = 1; s.rs = 6; s.rena1 = 1; s.flush = 1; s.pc = 32'h404; step(s, 0);
    s = idle(); s.id_valid = 1; s.rs = 7; s.rena1 = 1; s.rdata1 = 32'h55; s.imm = 32'h66;
    s.aluop = 5'd2; s.waddr = 8; s.wena = 1; s.mw = 1; s.pc = 32'h408; step(s, 0);
    s = idle(); s.id_valid = 1; s.rs = 9; s.rena1 = 1; s.rdata1 = 32'hFF; s.ex_hold = 1;
    s.pc = 32'h40C; step(s, 0); step(s, 0);

    // back-to-back dependency: count bubbles until the consumer is accepted
    s = idle(); s.rst = 1; step(s, 1);
    s = idle(); s.id_valid = 1; s.wena = 1; s.waddr = 4; s.aluop = 5'd1; s.pc = 32'h500;
    step(s, 1);
    s = idle(); s.id_valid = 1; s.rs = 4; s.rena1 = 1; s.rdata1 = 32'h44; s.ex_res = 32'h40;
    s.mem_wdata = 32'h41; s.pc = 32'h504;
    guard = 0;
    do begin
      step(s, 1);
      guard++;
    end while (model_stall && guard < 8);
    if (guard >= 8) begin
      n_cmp++; n_bad++;
      $display("FAIL t5_budget: consumer not accepted within %0d cycles", guard);
    end
    chk("t5_bubbles", {28'd0, stall_cycles}, T5_BUBBLES);

    // reset asserted during a stall
    s = idle(); s.id_valid = 1; s.wena = 1; s.waddr = 5; s.mr = 1; s.pc = 32'h600; step(s, 1);
    s = idle(); s.id_valid = 1; s.rs = 5; s.rena1 = 1; s.rst = 1; s.pc = 32'h604; step(s, 1);

    // counter saturation
    s = idle(); s.id_valid = 1; s.ex_hold = 1;
    repeat (20) step(s, 1);
    s = idle(); step(s, 1);
    chk("stall_sat", {28'd0, stall_cycles}, {28'd0, {CNT_W{1'b1}}});

    repeat (2000) step(rand_stim(), 1);

    s = idle(); step(s, 1); step(s, 1);
    @(posedge clk);
    #3;
    chk("sb_drain", q_seq.size() + q_comb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
